ct_spsram_256x196_ctrl: RTL and testbench
=========================================

Name: ct_spsram_256x196_ctrl

Overview:
- Controller and arbiter in front of one 256x196 single-port SRAM macro (active-low CEN/GWEN/WEN).
- Shares the single port between a read requester and a write requester using round-robin arbitration.
- After reset, and on a flush request, it runs an init sweep that writes zeros to all 256 entries.
- Sits between the cache/array pipeline logic and the SRAM wrapper. It drives the macro pins directly and returns read data with a valid strobe.

Parameters:
- ADDR_WIDTH, 8, SRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 196, data and bit-write-mask width.
- INIT_DATA, 196'b0, value written to every entry during the init sweep.

Ports:
- CLK  input  1  single clock for the controller and the SRAM.
- RST  input  1  asynchronous, active-high reset.
- flush_req  input  1  one-cycle pulse that starts a re-init sweep.
- init_done  output  1  high when the array is initialised and accepting requests.
- rd_vld  input  1  read request valid.
- rd_addr  input  8  read address.
- rd_rdy  output  1  read request accepted this cycle.
- rd_rvld  output  1  read data valid.
- rd_rdata  output  196  read data.
- wr_vld  input  1  write request valid.
- wr_addr  input  8  write address.
- wr_data  input  196  write data.
- wr_mask  input  196  active-high per-bit write enable.
- wr_rdy  output  1  write request accepted this cycle.
- sram_a  output  8  SRAM address.
- sram_cen  output  1  SRAM chip enable, active-low.
- sram_gwen  output  1  SRAM global write enable, active-low.
- sram_wen  output  196  SRAM bit write enable, active-low.
- sram_d  output  196  SRAM write data.
- sram_q  input  196  SRAM read data; valid one cycle after a read access.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - FSM = INIT, init counter = 0, rr pointer = write-preferred.
  - init_done = 0, rd_rdy = 0, wr_rdy = 0, rd_rvld = 0, rd_rdata = 0.
  - sram_cen = 1, sram_gwen = 1, sram_wen = all-1, sram_a = 0, sram_d = 0.
- FSM states: INIT and RUN.
  - INIT: each cycle issues a full write of INIT_DATA to address cnt (cen=0, gwen=0, wen=all-0), then cnt increments.
  - When cnt = 255 is written, the next state is RUN. cnt wraps to 0; there is no extra cycle.
  - A full sweep is exactly 256 cycles. init_done rises in the first RUN cycle.
  - RUN: arbitrates requests as described below.
  - flush_req in RUN: next state is INIT and cnt = 0. Any grant in that same cycle still completes.
  - flush_req in INIT: restarts the sweep at cnt = 0.
  - RST asserted mid-sweep: the sweep restarts from 0 after reset release.
- Handshake:
  - rd_rdy and wr_rdy are combinational grants, asserted only in RUN.
  - A request completes when vld and rdy are both high. Requesters hold vld, addr and data stable until granted.
- Arbitration:
  - Only one request pending: it is granted every cycle, with no bubbles.
  - Both pending: round-robin. The pointer flips after each contended grant, so rd and wr alternate under continuous contention.
- SRAM pin drive: pins are registered; the access occurs at the CLK edge after the grant.
  - Read access: cen=0, gwen=1, wen=all-1.
  - Write access: cen=0, gwen=0, wen = ~wr_mask, d = wr_data.
  - Idle: cen=1, gwen=1, wen=all-1.
- Read latency:
  - The grant registers the pins at edge N, and the SRAM samples at edge N+1.
  - rd_rvld is high for one cycle after edge N+1, with rd_rdata = sram_q (pass-through).
  - Reads are fully pipelined: back-to-back reads give back-to-back rvld.
- Same-address write then read: the accesses are serialized, so the read sees the written data. No bypass path exists.
- A read granted in the cycle that flush_req arrives still returns rd_rvld with pre-flush data.

Optional Feature:
- Macro: CT_SPSRAM_CTRL_QREG_EN.
- Defined:
  - rd_rdata is a flop capturing sram_q, and rd_rvld is delayed one more cycle. Read latency is +1 versus undefined.
  - rd_rdata holds its value between reads.
- Undefined: rd_rdata = sram_q combinationally, with latency as in Behaviour.

Decomposition:
- Shared package ct_spsram_ctrl_pkg holds:
  - the FSM state enum (INIT, RUN);
  - constants for SRAM pin idle values: CEN_IDLE = 1, GWEN_IDLE = 1, WEN_IDLE = all-1;
  - the DEPTH constant.
- One sub-module is natural: ct_spsram_ctrl_rr_arb, the 2-requester round-robin arbiter (req[1:0] in, gnt[1:0] out, pointer flop).

Test Plan:
- Reset release: the bench monitors the SRAM pins. Required response: 256 consecutive writes to addresses 0..255 with wen=all-0 and d=0, then init_done=1 in the next cycle, with rd_rdy/wr_rdy = 0 throughout the sweep.
- Write then read, same address: write addr=0x3C, data=0x5A..5A, mask=all-1, followed by a read of 0x3C. Required response: rd_rvld pulses with rd_rdata = 0x5A..5A at the specified latency (1 or 2).
- Partial mask: write mask=0x0FF (bits 7:0) with data=all-1 to addr 0x10, then read. Required response: rd_rdata[7:0] = 0xFF and all other bits = 0; sram_wen = ~0x0FF during the write.
- Continuous contention: rd_vld and wr_vld both held high for 8 cycles. Required response: grants alternate (wr, rd, wr, rd, ...), with exactly 4 of each.
- Flush mid-traffic: pulse flush_req in a cycle where a read is granted. Required response:
  - that read still returns rd_rvld;
  - init_done drops next cycle, a 256-cycle sweep follows, then a read of any address returns 0.
- Reset mid-sweep: assert RST at cnt = 100. Required response: pins return to idle values immediately, and after release the sweep restarts at address 0.

Source files
------------

// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the 256x196 single-port SRAM controller.
// FSM state encoding, SRAM pin idle levels and the array depth.
package ct_spsram_ctrl_pkg;

    localparam int DEPTH_ADDR_WIDTH = 8;
    localparam int DEPTH            = 2 ** DEPTH_ADDR_WIDTH;
    localparam int WORD_WIDTH       = 196;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SRAM pins are active-low; these are the "no access" levels.
    localparam logic                  CEN_IDLE  = 1'b1;
    localparam logic                  GWEN_IDLE = 1'b1;
    localparam logic [WORD_WIDTH-1:0] WEN_IDLE  = '1;

endpackage

// File: rtl/ct_spsram_256x196_ctrl_if.sv
// Bus bundle for the SRAM controller: read/write requester handshakes,
// flush/init status and the SRAM macro pins.
// master = requester/macro side, slave = controller side.
interface ct_spsram_256x196_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 196
);

    logic                  flush_req;
    logic                  init_done;

    logic                  rd_vld;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_rdy;
    logic                  rd_rvld;
    logic [DATA_WIDTH-1:0] rd_rdata;

    logic                  wr_vld;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  wr_rdy;

    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  flush_req, rd_vld, rd_addr, wr_vld, wr_addr, wr_data, wr_mask, sram_q,
        output init_done, rd_rdy, rd_rvld, rd_rdata, wr_rdy,
        output sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    modport master (
        output flush_req, rd_vld, rd_addr, wr_vld, wr_addr, wr_data, wr_mask, sram_q,
        input  init_done, rd_rdy, rd_rvld, rd_rdata, wr_rdy,
        input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

endinterface

// File: rtl/ct_spsram_ctrl_rr_arb.sv
// Two-requester round-robin arbiter. req[0] = read, req[1] = write.
// A lone request is always granted; under contention the pointer decides
// and flips after each contended grant, so the two sides alternate.
module ct_spsram_ctrl_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1 = write side wins the next contended cycle
    logic prefer_wr;

    // Grant selection: single requester passes through, contention uses pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prefer_wr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer only moves when both sides were asking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_wr <= 1'b1;
        end else if (&req) begin
            prefer_wr <= ~prefer_wr;
        end
    end

endmodule

// File: rtl/ct_spsram_256x196_ctrl.sv
// Controller/arbiter in front of a 256x196 single-port SRAM macro.
// After reset or flush it sweeps INIT_DATA into every entry, then shares
// the port between a read and a write requester (round-robin).
// Optional: define CT_SPSRAM_CTRL_QREG_EN to register sram_q into rd_rdata
// (one extra cycle of read latency, rd_rdata holds between reads).
module ct_spsram_256x196_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 196,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0
) (
    input  logic                      CLK,
    input  logic                      RST,
    ct_spsram_256x196_ctrl_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  run;
    logic [1:0]            req, gnt;

    // read issued on the pins (p0), SRAM data present on sram_q (p1)
    logic                  rd_vld_p0;
    logic                  rd_vld_p1;

    assign run           = (state == ST_RUN);
    assign req           = {bus.wr_vld & run, bus.rd_vld & run};
    assign bus.rd_rdy    = gnt[0];
    assign bus.wr_rdy    = gnt[1];
    assign bus.init_done = run;

    ct_spsram_ctrl_rr_arb u_arb (
        .clk (CLK),
        .rst (RST),
        .req (req),
        .gnt (gnt)
    );

    // FSM state and init sweep counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: sweep one entry per cycle, flush restarts from entry 0
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                if (bus.flush_req) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---- p0: register SRAM pins (init write, granted write/read, or idle)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.sram_cen  <= CEN_IDLE;
            bus.sram_gwen <= GWEN_IDLE;
            bus.sram_wen  <= WEN_IDLE;
            bus.sram_a    <= '0;
            bus.sram_d    <= '0;
        end else if (!run) begin
            bus.sram_cen  <= 1'b0;
            bus.sram_gwen <= 1'b0;
            bus.sram_wen  <= '0;
            bus.sram_a    <= cnt;
            bus.sram_d    <= INIT_DATA;
        end else if (gnt[1]) begin
            bus.sram_cen  <= 1'b0;
            bus.sram_gwen <= 1'b0;
            bus.sram_wen  <= ~bus.wr_mask;
            bus.sram_a    <= bus.wr_addr;
            bus.sram_d    <= bus.wr_data;
        end else if (gnt[0]) begin
            bus.sram_cen  <= 1'b0;
            bus.sram_gwen <= GWEN_IDLE;
            bus.sram_wen  <= WEN_IDLE;
            bus.sram_a    <= bus.rd_addr;
        end else begin
            bus.sram_cen  <= CEN_IDLE;
            bus.sram_gwen <= GWEN_IDLE;
            bus.sram_wen  <= WEN_IDLE;
        end
    end

    // ---- p0/p1: read-valid pipeline tracking the SRAM's one-cycle access
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p0 <= run & gnt[0];
            rd_vld_p1 <= rd_vld_p0;
        end
    end

`ifdef CT_SPSRAM_CTRL_QREG_EN
    logic                  rd_vld_p2;
    logic [DATA_WIDTH-1:0] rd_rdata_p2;

    // ---- p2: capture sram_q and hold it until the next read returns
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld_p2   <= 1'b0;
            rd_rdata_p2 <= '0;
        end else begin
            rd_vld_p2 <= rd_vld_p1;
            if (rd_vld_p1) begin
                rd_rdata_p2 <= bus.sram_q;
            end
        end
    end

    assign bus.rd_rvld  = rd_vld_p2;
    assign bus.rd_rdata = rd_rdata_p2;
`else
    assign bus.rd_rvld  = rd_vld_p1;
    assign bus.rd_rdata = bus.sram_q;
`endif

endmodule

// File: tb/tb_ct_spsram_256x196_ctrl.sv
// Bench for ct_spsram_256x196_ctrl: behavioural SRAM macro, reference
// memory plus read scoreboard, and a directed sequence of scenarios.
module tb_ct_spsram_256x196_ctrl;
    import ct_spsram_ctrl_pkg::*;

    localparam int AW = 8;
    localparam int DW = 196;
`ifdef CT_SPSRAM_CTRL_QREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef logic [DW-1:0] word_t;
    typedef struct {
        word_t       data;
        int unsigned cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    int unsigned cyc = 0;
    int          passed = 0;
    int          total = 0;
    exp_t        sbq[$];
    word_t       model [DEPTH];
    word_t       sram_mem [DEPTH];
    word_t       q_r = '0;
    word_t       last_rdata = '0;
    word_t       pat;

    ct_spsram_256x196_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_spsram_256x196_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_DATA  ('0)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural SRAM macro: active-low pins, q one cycle after a read
    always @(posedge CLK) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_gwen)
                sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
            else
                q_r <= sram_mem[bus.sram_a];
        end
    end
    assign bus.sram_q = q_r;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Monitor: reference memory, scoreboard push on read grant, pop on rvld
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else begin
            if (bus.rd_rvld) begin
                if (sbq.size() == 0) begin
                    chk("rvld_unexpected", word_t'(1), word_t'(0));
                end else begin
                    e = sbq.pop_front();
                    last_rdata = bus.rd_rdata;
                    chk("rd_rdata", bus.rd_rdata, e.data);
                    chk("rd_latency", word_t'(cyc - e.cyc), word_t'(LAT));
                end
            end
            if (bus.wr_vld && bus.wr_rdy)
                model[bus.wr_addr] = (model[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
            if (bus.rd_vld && bus.rd_rdy)
                sbq.push_back('{model[bus.rd_addr], cyc});
            if (bus.flush_req && bus.init_done)
                for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end
    end

    // Called at posedge+1; follows an init sweep with requests held high
    task automatic sweep_check(input string tag);
        int nwr = 0;
        int lowcyc = 0;
        bit seq_ok = 1'b1;
        bit rdy_ok = 1'b1;
        bit done = 1'b0;
        bus.rd_vld = 1'b1; bus.rd_addr = '0;
        bus.wr_vld = 1'b1; bus.wr_addr = '0; bus.wr_data = '1; bus.wr_mask = '1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK);
            if (!bus.sram_cen && !bus.sram_gwen) begin
                if (bus.sram_wen != '0 || bus.sram_d != '0 || bus.sram_a != AW'(nwr)) seq_ok = 1'b0;
                nwr++;
            end
            if (bus.init_done) begin
                done = 1'b1;
            end else begin
                lowcyc++;
                if (bus.rd_rdy || bus.wr_rdy) rdy_ok = 1'b0;
                @(posedge CLK); #1;
                if (bus.init_done) begin
                    bus.rd_vld = 1'b0;
                    bus.wr_vld = 1'b0;
                end
            end
        end
        bus.rd_vld = 1'b0;
        bus.wr_vld = 1'b0;
        chk({tag, "_done"}, word_t'(done), word_t'(1));
        chk({tag, "_writes"}, word_t'(nwr), word_t'(DEPTH));
        chk({tag, "_addr_seq"}, word_t'(seq_ok), word_t'(1));
        chk({tag, "_rdy_low"}, word_t'(rdy_ok), word_t'(1));
        chk({tag, "_init_cycles"}, word_t'(lowcyc), word_t'(DEPTH));
        @(posedge CLK); #1;
    endtask

    task automatic wr_req(input logic [AW-1:0] a, input word_t d, input word_t m);
        bit g = 1'b0;
        bus.wr_vld = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_mask = m;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge CLK);
            g = bus.wr_rdy;
            @(posedge CLK); #1;
        end
        bus.wr_vld = 1'b0;
        chk("wr_granted", word_t'(g), word_t'(1));
        @(negedge CLK);
        chk("wr_pin_cen_gwen", word_t'({bus.sram_cen, bus.sram_gwen}), word_t'(0));
        chk("wr_pin_addr", word_t'(bus.sram_a), word_t'(a));
        chk("wr_pin_wen", bus.sram_wen, ~m);
        chk("wr_pin_d", bus.sram_d, d);
        @(posedge CLK); #1;
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        bit g = 1'b0;
        bus.rd_vld = 1'b1; bus.rd_addr = a;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge CLK);
            g = bus.rd_rdy;
            @(posedge CLK); #1;
        end
        bus.rd_vld = 1'b0;
        chk("rd_granted", word_t'(g), word_t'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        chk("sb_drained", word_t'(sbq.size()), word_t'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int nr;
        bit found;
        pat = {4'hA, {24{8'h5A}}};
        RST = 1'b1;
        bus.flush_req = 1'b0;
        bus.rd_vld = 1'b1; bus.rd_addr = '0;
        bus.wr_vld = 1'b1; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cen", word_t'(bus.sram_cen), word_t'(1));
        chk("rst_gwen", word_t'(bus.sram_gwen), word_t'(1));
        chk("rst_wen", bus.sram_wen, '1);
        chk("rst_a", word_t'(bus.sram_a), word_t'(0));
        chk("rst_d", bus.sram_d, '0);
        chk("rst_flags", word_t'({bus.init_done, bus.rd_rdy, bus.wr_rdy, bus.rd_rvld}), word_t'(0));
        chk("rst_rdata", bus.rd_rdata, '0);
        @(posedge CLK); #1;
        RST = 1'b0;
        sweep_check("reset_sweep");

        // Same-address write then read
        wr_req(8'h3C, pat, '1);
        rd_req(8'h3C);
        drain();
        chk("wr_rd_same_addr", last_rdata, pat);

        // Partial bit mask
        wr_req(8'h10, '1, word_t'(8'hFF));
        rd_req(8'h10);
        drain();
        chk("partial_mask", last_rdata, word_t'(8'hFF));

        // Continuous contention: 8 cycles, expect wr,rd,wr,rd,...
        nw = 0; nr = 0;
        bus.rd_vld = 1'b1; bus.rd_addr = 8'h20;
        bus.wr_vld = 1'b1; bus.wr_addr = 8'h20; bus.wr_data = ~pat; bus.wr_mask = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("contend_grant", word_t'({bus.wr_rdy, bus.rd_rdy}), word_t'((i % 2 == 0) ? 2'b10 : 2'b01));
            nw += int'(bus.wr_rdy);
            nr += int'(bus.rd_rdy);
            @(posedge CLK); #1;
        end
        bus.rd_vld = 1'b0; bus.wr_vld = 1'b0;
        chk("contend_wr_count", word_t'(nw), word_t'(4));
        chk("contend_rd_count", word_t'(nr), word_t'(4));
        drain();
        chk("contend_last_read", last_rdata, ~pat);

        // Back-to-back reads must be granted every cycle
        bus.rd_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rd_addr = (i == 0) ? 8'h3C : ((i == 1) ? 8'h10 : 8'h20);
            @(negedge CLK);
            chk("b2b_rd_rdy", word_t'(bus.rd_rdy), word_t'(1));
            @(posedge CLK); #1;
        end
        bus.rd_vld = 1'b0;
        drain();

        // Flush in a cycle with a granted read
        bus.rd_vld = 1'b1; bus.rd_addr = 8'h3C; bus.flush_req = 1'b1;
        @(negedge CLK);
        chk("flush_rd_rdy", word_t'(bus.rd_rdy), word_t'(1));
        @(posedge CLK); #1;
        bus.rd_vld = 1'b0; bus.flush_req = 1'b0;
        sweep_check("flush_sweep");
        chk("flush_read_returned", word_t'(sbq.size()), word_t'(0));
        chk("flush_read_data", last_rdata, pat);
        rd_req(8'h3C);
        drain();
        chk("post_flush_zero", last_rdata, '0);

        // Reset in the middle of a sweep (controller counter at 100)
        bus.flush_req = 1'b1;
        @(posedge CLK); #1;
        bus.flush_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge CLK);
            found = !bus.sram_cen && !bus.sram_gwen && bus.sram_a == 8'd99;
        end
        chk("midsweep_reached", word_t'(found), word_t'(1));
        RST = 1'b1;
        #1;
        chk("midrst_cen_gwen", word_t'({bus.sram_cen, bus.sram_gwen}), word_t'(2'b11));
        chk("midrst_wen", bus.sram_wen, '1);
        chk("midrst_a", word_t'(bus.sram_a), word_t'(0));
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        sweep_check("rst_sweep");
        rd_req(8'h10);
        drain();
        chk("post_rst_zero", last_rdata, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
